// File: rtl/rfid_pkg.sv
// Shared types and constants for the tag-side FM0 backlink transmitter.
package rfid_pkg;

   // Transmitter phases, in the order a frame walks through them.
   typedef enum logic [2:0] {
      IDLE,
      PILOT,
      PREAMBLE,
      DATA,
      DUMMY,
      DONE
   } tx_state_t;

   // FM0 preamble as twelve half-symbol levels, sent MSB first; contains the
   // deliberate FM0 violation so the reader can find symbol alignment.
   localparam int                      PREAMBLE_HS  = 12;
   localparam logic [PREAMBLE_HS-1:0] FM0_PREAMBLE = 12'b1101_0010_0011;

   // Half-symbol counter width; restarts at zero on every phase change.
   localparam int HS_W = 5;

endpackage

// File: rtl/rfid_transmit_fm0_encoder.sv
// One FM0 half-symbol: the level to drive next, given the data bit, which
// half of the symbol is being produced and the level currently on the line.
module fm0_encoder (
   input  logic bit_i,    // data bit of the current symbol
   input  logic half_i,   // 0 = first half, 1 = second half
   input  logic prev_i,   // level currently driven
   output logic level_o   // level for the requested half-symbol
);

   // Every symbol boundary inverts; a data-0 also inverts mid-symbol.
   assign level_o = (half_i && bit_i) ? prev_i : ~prev_i;

endmodule

// File: rtl/rfid_transmit.sv
// Tag backlink transmitter: serialises a left-justified reply as FM0 baseband,
// one half-symbol per clock: optional pilot, preamble, data, dummy 1.
module rfid_transmit
   import rfid_pkg::*;
#(
   parameter int MAX_BITS   = 128,
   parameter int LEN_W      = 8,
   parameter int PILOT_SYMS = 12
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [MAX_BITS-1:0] packet,
   input  logic [LEN_W-1:0]    packet_len,
   input  logic                trext,
   input  logic                tx_start,
   output logic                BL_data,
   output logic                tx_busy,
   output logic                tx_done
);

   localparam int CNT_W = $clog2(MAX_BITS + 1);

   tx_state_t           state_q, state_d;
   logic [HS_W-1:0]     hs_q, hs_d;
   logic [CNT_W-1:0]    bit_q, bit_d;
   logic [MAX_BITS-1:0] shift_q, shift_d;
   logic                bl_q, bl_d;

   logic [CNT_W-1:0]    len_clamped;
   logic [3:0]          pre_idx;
   logic                pilot_last, pre_last, data_last, dummy_last;
   logic                enc_bit, enc_half, enc_level;

   // Requested length, limited to what the packet register can hold.
   always_comb begin
      if (int'(packet_len) > MAX_BITS) len_clamped = CNT_W'(MAX_BITS);
      else                             len_clamped = CNT_W'(packet_len);
   end

   // Terminal-count flags for each phase; a DATA symbol ends on its odd half.
   assign pilot_last = (hs_q == HS_W'(2 * PILOT_SYMS - 1));
   assign pre_last   = (hs_q == HS_W'(PREAMBLE_HS - 1));
   assign data_last  = hs_q[0] && (bit_q == CNT_W'(1));
   assign dummy_last = hs_q[0];
   assign pre_idx    = 4'(PREAMBLE_HS - 2) - hs_q[3:0];

   // State and datapath registers; reset aborts any frame in progress.
   // NOTE: non-blocking assignments here so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         hs_q    <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         bl_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         hs_q    <= hs_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         bl_q    <= bl_d;
      end
   end

   // Next phase: advance on each phase's terminal count.
   // NOTE: default assignment first so no path through the case infers a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (tx_start)   state_d = trext ? PILOT : PREAMBLE;
         PILOT:    if (pilot_last) state_d = PREAMBLE;
         PREAMBLE: if (pre_last)   state_d = (bit_q == '0) ? DUMMY : DATA;
         DATA:     if (data_last)  state_d = DUMMY;
         DUMMY:    if (dummy_last) state_d = DONE;
         DONE:                     state_d = IDLE;
         default:                  state_d = IDLE;
      endcase
   end

   // Encoder operands: the half-symbol being produced for the next cycle.
   always_comb begin
      enc_bit  = 1'b1;
      enc_half = 1'b0;
      case (state_q)
         DATA: begin
            enc_bit  = shift_q[MAX_BITS-1];
            enc_half = ~hs_q[0];
         end
         DUMMY:   enc_half = 1'b1;
         default: enc_half = 1'b0;
      endcase
   end

   fm0_encoder u_fm0_encoder (
      .bit_i   (enc_bit),
      .half_i  (enc_half),
      .prev_i  (bl_q),
      .level_o (enc_level)
   );

   // Datapath next-state: latch the request, shift per symbol, pick next level.
   always_comb begin
      shift_d = shift_q;
      bit_d   = bit_q;
      hs_d    = (state_q == IDLE || state_d != state_q) ? '0 : hs_q + HS_W'(1);
      bl_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (tx_start) begin
               shift_d = packet;
               bit_d   = len_clamped;
               bl_d    = trext ? 1'b1 : FM0_PREAMBLE[PREAMBLE_HS-1];
            end
         end
         PILOT:    bl_d = pilot_last ? FM0_PREAMBLE[PREAMBLE_HS-1] : ~bl_q;
         PREAMBLE: bl_d = pre_last ? enc_level : FM0_PREAMBLE[pre_idx];
         DATA: begin
            bl_d = enc_level;
            if (hs_q[0]) begin
               shift_d = shift_q << 1;
               bit_d   = bit_q - CNT_W'(1);
            end
         end
         DUMMY:   bl_d = dummy_last ? 1'b0 : enc_level;
         default: bl_d = 1'b0;
      endcase
   end

   // Status outputs decoded from the registered phase.
   always_comb begin
      tx_busy = (state_q == PILOT) || (state_q == PREAMBLE) ||
                (state_q == DATA)  || (state_q == DUMMY);
      tx_done = (state_q == DONE);
   end

   assign BL_data = bl_q;

endmodule

// File: tb/tb_rfid_transmit.sv
// Directed bench for rfid_transmit: frame lengths, FM0 waveforms, start
// filtering, clamping and mid-frame reset.
module tb_rfid_transmit;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic [127:0] packet = '0;
   logic [7:0]   packet_len = '0;
   logic         trext = 1'b0;
   logic         tx_start = 1'b0;
   logic         BL_data, tx_busy, tx_done;

   int   errors = 0;
   int   checks = 0;
   logic got_q[$];
   logic exp_q[$];
   logic done_seen, bl_at_done, done_after;

   rfid_transmit #(.MAX_BITS(128), .LEN_W(8), .PILOT_SYMS(12)) dut (
      .clock      (clock),
      .reset      (reset),
      .packet     (packet),
      .packet_len (packet_len),
      .trext      (trext),
      .tx_start   (tx_start),
      .BL_data    (BL_data),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done)
   );

   always #5 clock = ~clock;

   // Reference waveform built straight from the FM0 rules.
   task automatic build_expected(input logic [127:0] pkt, input int len, input logic tr);
      logic [11:0] pre;
      logic        lvl;
      int          n;
      pre = 12'b1101_0010_0011;
      exp_q.delete();
      n = (len > 128) ? 128 : len;
      if (tr) for (int i = 0; i < 24; i++) exp_q.push_back((i % 2) == 0);
      for (int i = 11; i >= 0; i--) exp_q.push_back(pre[i]);
      lvl = 1'b1;
      for (int i = 0; i < n; i++) begin
         lvl = ~lvl;
         exp_q.push_back(lvl);
         if (!pkt[127-i]) lvl = ~lvl;
         exp_q.push_back(lvl);
      end
      lvl = ~lvl;
      exp_q.push_back(lvl);
      exp_q.push_back(lvl);
   endtask

   // Index of first differing half-symbol, size if lengths differ, -1 if equal.
   function automatic int first_diff();
      if (got_q.size() != exp_q.size()) return got_q.size();
      for (int i = 0; i < got_q.size(); i++)
         if (got_q[i] !== exp_q[i]) return i;
      return -1;
   endfunction

   // Called at a negedge; leaves us at the negedge of the first busy cycle.
   // Inputs are scrambled afterwards, which must not affect the frame.
   task automatic start_frame(input logic [127:0] pkt, input logic [7:0] len, input logic tr);
      packet = pkt; packet_len = len; trext = tr; tx_start = 1'b1;
      @(negedge clock);
      tx_start = 1'b0; packet = ~pkt; packet_len = 8'd3; trext = ~tr;
   endtask

   // Record BL_data while busy (bounded), then sample the DONE cycle and the
   // cycle after. Optionally pulse tx_start at busy cycle poke_at and in DONE.
   task automatic capture(input int poke_at, input bit poke_done, output int n);
      n = 0;
      got_q.delete();
      while (tx_busy === 1'b1 && n < 400) begin
         tx_start = (n == poke_at);
         got_q.push_back(BL_data);
         n++;
         @(negedge clock);
      end
      tx_start   = poke_done;
      done_seen  = tx_done;
      bl_at_done = BL_data;
      @(negedge clock);
      tx_start   = 1'b0;
      done_after = tx_done;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      checks++; if (BL_data !== 1'b0) begin errors++; $display("FAIL reset_bl: got %b want 0", BL_data); end
      checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
      checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", tx_done); end
      @(negedge clock); @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", tx_busy); end
   endtask

   task automatic test_rn16();
      int n, d;
      logic [127:0] pkt;
      pkt = {16'h5555, 112'h0};
      build_expected(pkt, 16, 1'b0);
      start_frame(pkt, 8'd16, 1'b0);
      capture(-1, 1'b0, n);
      d = first_diff();
      checks++; if (n !== 46) begin errors++; $display("FAIL rn16_busy: got %0d cycles want 46", n); end
      checks++; if (d != -1) begin errors++; $display("FAIL rn16_wave: first difference at half-symbol %0d", d); end
      checks++; if (done_seen !== 1'b1 || bl_at_done !== 1'b0) begin errors++; $display("FAIL rn16_done: done=%b bl=%b want 1 0", done_seen, bl_at_done); end
      checks++; if (done_after !== 1'b0) begin errors++; $display("FAIL rn16_done_pulse: done next cycle=%b want 0", done_after); end
   endtask

   task automatic test_two_bits();
      int n;
      logic [5:0] tail;
      logic [127:0] pkt;
      pkt = {2'b01, 126'h0};
      start_frame(pkt, 8'd2, 1'b0);
      capture(-1, 1'b0, n);
      tail = 'x;
      if (got_q.size() == 18) tail = {got_q[12], got_q[13], got_q[14], got_q[15], got_q[16], got_q[17]};
      checks++; if (n !== 18) begin errors++; $display("FAIL two_busy: got %0d cycles want 18", n); end
      checks++; if (tail !== 6'b010011) begin errors++; $display("FAIL two_wave: got %b want 010011", tail); end
      checks++; if (done_seen !== 1'b1 || bl_at_done !== 1'b0) begin errors++; $display("FAIL two_done: done=%b bl=%b want 1 0", done_seen, bl_at_done); end
   endtask

   task automatic test_pilot();
      int n, d;
      logic bad;
      logic [127:0] pkt;
      pkt = {16'hC3A5, 112'h0};
      build_expected(pkt, 16, 1'b1);
      start_frame(pkt, 8'd16, 1'b1);
      capture(-1, 1'b0, n);
      bad = (got_q.size() < 24);
      if (!bad) for (int i = 0; i < 24; i++) if (got_q[i] !== ((i % 2) == 0)) bad = 1'b1;
      d = first_diff();
      checks++; if (n !== 70) begin errors++; $display("FAIL pilot_busy: got %0d cycles want 70", n); end
      checks++; if (bad) begin errors++; $display("FAIL pilot_tone: first 24 half-symbols not 1010..."); end
      checks++; if (d != -1) begin errors++; $display("FAIL pilot_wave: first difference at half-symbol %0d", d); end
   endtask

   task automatic test_len_bounds();
      int n, d;
      logic [127:0] pkt;
      pkt = 128'hFFFF_0000_1234_5678_9ABC_DEF0_0F0F_A5A5;
      build_expected(pkt, 0, 1'b0);
      start_frame(pkt, 8'd0, 1'b0);
      capture(-1, 1'b0, n);
      d = first_diff();
      checks++; if (n !== 14) begin errors++; $display("FAIL len0_busy: got %0d cycles want 14", n); end
      checks++; if (d != -1) begin errors++; $display("FAIL len0_wave: first difference at half-symbol %0d", d); end
      build_expected(pkt, 200, 1'b0);
      start_frame(pkt, 8'd200, 1'b0);
      capture(-1, 1'b0, n);
      d = first_diff();
      checks++; if (n !== 270) begin errors++; $display("FAIL len200_busy: got %0d cycles want 270", n); end
      checks++; if (d != -1) begin errors++; $display("FAIL len200_wave: first difference at half-symbol %0d", d); end
   endtask

   task automatic test_ignore_start();
      int n, d, stray;
      logic [127:0] pkt;
      pkt = {16'h5555, 112'h0};
      build_expected(pkt, 16, 1'b0);
      start_frame(pkt, 8'd16, 1'b0);
      capture(22, 1'b1, n);
      d = first_diff();
      stray = 0;
      repeat (3) begin
         if (tx_busy !== 1'b0) stray++;
         @(negedge clock);
      end
      checks++; if (n !== 46) begin errors++; $display("FAIL ignore_busy: got %0d cycles want 46", n); end
      checks++; if (d != -1) begin errors++; $display("FAIL ignore_wave: first difference at half-symbol %0d", d); end
      checks++; if (stray != 0) begin errors++; $display("FAIL ignore_done_start: busy seen %0d cycles after DONE want 0", stray); end
   endtask

   task automatic test_back_to_back();
      int n, d;
      logic [127:0] pkt;
      pkt = {2'b01, 126'h0};
      start_frame(pkt, 8'd2, 1'b0);
      capture(-1, 1'b0, n);
      pkt = {8'hB4, 120'h0};
      build_expected(pkt, 8, 1'b0);
      start_frame(pkt, 8'd8, 1'b0);
      capture(-1, 1'b0, n);
      d = first_diff();
      checks++; if (n !== 30) begin errors++; $display("FAIL b2b_busy: got %0d cycles want 30", n); end
      checks++; if (d != -1) begin errors++; $display("FAIL b2b_wave: first difference at half-symbol %0d", d); end
   endtask

   task automatic test_reset_mid();
      int n, d, done_cnt;
      logic [127:0] pkt;
      pkt = {16'h5555, 112'h0};
      start_frame(pkt, 8'd16, 1'b0);
      repeat (13) @(negedge clock);
      checks++; if (BL_data !== 1'b1) begin errors++; $display("FAIL mid_pre: BL_data=%b want 1 at data half 1", BL_data); end
      #1 reset = 1'b1;
      #1;
      checks++; if (BL_data !== 1'b0 || tx_busy !== 1'b0) begin errors++; $display("FAIL mid_async: bl=%b busy=%b want 0 0", BL_data, tx_busy); end
      @(negedge clock);
      reset = 1'b0;
      done_cnt = 0;
      repeat (5) begin
         if (tx_done !== 1'b0 || tx_busy !== 1'b0) done_cnt++;
         @(negedge clock);
      end
      checks++; if (done_cnt != 0) begin errors++; $display("FAIL mid_no_done: activity in %0d cycles after reset want 0", done_cnt); end
      build_expected(pkt, 16, 1'b0);
      start_frame(pkt, 8'd16, 1'b0);
      capture(-1, 1'b0, n);
      d = first_diff();
      checks++; if (n !== 46 || d != -1) begin errors++; $display("FAIL mid_refram: busy=%0d want 46, diff at %0d", n, d); end
   endtask

   initial begin
      #2;
      test_reset();
      test_rn16();
      test_two_bits();
      test_pilot();
      test_len_bounds();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
